// File: rtl/lsu_ctrl_if.sv
// Data-memory request/acknowledge bus between lsu_ctrl (master) and data memory (slave).
interface lsu_ctrl_if;
  logic        DMEM_req;
  logic        DMEM_we;
  logic [31:0] DMEM_address;
  logic [31:0] DMEM_data_in;
  logic [3:0]  DMEM_byte_en;
  logic        DMEM_ack;
  logic [31:0] DMEM_data_out;

  modport master (
    output DMEM_req, DMEM_we, DMEM_address, DMEM_data_in, DMEM_byte_en,
    input  DMEM_ack, DMEM_data_out
  );

  modport slave (
    input  DMEM_req, DMEM_we, DMEM_address, DMEM_data_in, DMEM_byte_en,
    output DMEM_ack, DMEM_data_out
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one memory op per start pulse, lane formatting and fault reporting.
// Optional bus timeout fault enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        LSU_start,
  input  logic        LSU_write,
  input  logic [1:0]  LSU_size,
  input  logic        LSU_unsigned,
  input  logic [31:0] LSU_address,
  input  logic [31:0] LSU_wdata,
  output logic [31:0] LSU_rdata,
  output logic        LSU_busy,
  output logic        LSU_done,
  output logic        LSU_exception,
  output logic [1:0]  LSU_exc_code,
  output logic [31:0] LSU_bad_addr,
  lsu_ctrl_if.master  dmem
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        exc_q, exc_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] bad_q, bad_d;
`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic [3:0]  start_be;
  logic [31:0] start_wd;
  logic        start_misaligned;
  logic [31:0] lane;
  logic [31:0] load_fmt;

  if (TIMEOUT < 1 || TIMEOUT > (1 << CNT_W)) begin : g_cfg_check
    $error("lsu_ctrl: CNT_W cannot hold TIMEOUT-1");
  end

  always_comb begin
    start_be = 4'b1111;
    start_wd = LSU_wdata;
    case (LSU_size)
      2'b00: begin
        start_be = 4'b0001 << LSU_address[1:0];
        start_wd = {4{LSU_wdata[7:0]}};
      end
      2'b01: begin
        start_be = 4'b0011 << LSU_address[1:0];
        start_wd = {2{LSU_wdata[15:0]}};
      end
      default: ;
    endcase
    start_misaligned = (LSU_size == 2'b01 && LSU_address[0]) ||
                       (LSU_size == 2'b10 && LSU_address[1:0] != 2'b00);
  end

  // Shift the addressed lane down to bit 0, then extend by access size.
  always_comb begin
    lane     = dmem.DMEM_data_out >> {addr_q[1:0], 3'b000};
    load_fmt = lane;
    case (size_q)
      2'b00:   load_fmt = uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}},  lane[7:0]};
      2'b01:   load_fmt = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    exc_d   = 1'b0;
    code_d  = code_q;
    bad_d   = bad_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (LSU_start) begin
          we_d   = LSU_write;
          addr_d = LSU_address;
          wd_d   = start_wd;
          be_d   = start_be;
          size_d = LSU_size;
          uns_d  = LSU_unsigned;
          if (LSU_size == 2'b11 || start_misaligned) begin
            state_d = ERR;
            exc_d   = 1'b1;
            code_d  = (LSU_size == 2'b11) ? 2'b11 : 2'b01;
            bad_d   = LSU_address;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      REQ: begin
        if (dmem.DMEM_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) rdata_d = load_fmt;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ERR;
          req_d   = 1'b0;
          exc_d   = 1'b1;
          code_d  = 2'b10;
          bad_d   = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      exc_q   <= 1'b0;
      code_q  <= '0;
      bad_q   <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      code_q  <= code_d;
      bad_q   <= bad_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Busy is gated by reset so the core sees no stall while the unit is held in reset.
  assign LSU_busy      = SYS_reset & ((state_q == IDLE && LSU_start) || state_q == REQ);
  assign LSU_rdata     = rdata_q;
  assign LSU_done      = done_q;
  assign LSU_exception = exc_q;
  assign LSU_exc_code  = code_q;
  assign LSU_bad_addr  = bad_q;

  assign dmem.DMEM_req      = req_q;
  assign dmem.DMEM_we       = we_q;
  assign dmem.DMEM_address  = {addr_q[31:2], 2'b00};
  assign dmem.DMEM_data_in  = wd_q;
  assign dmem.DMEM_byte_en  = be_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl; timeout checks follow LSU_TIMEOUT_EN.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy, done, exc;
  logic [1:0]  exc_code;
  logic [31:0] bad_addr;

  int total = 0;
  int bad   = 0;

  // observations captured by the access task
  int          o_req_cycles;
  logic        o_busy0, o_done, o_busy_done, o_req_after, o_exc;
  logic [31:0] o_addr, o_din;
  logic [3:0]  o_be;
  logic        o_we;

  lsu_ctrl_if dmem ();

  always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
  lsu_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut (
`else
  lsu_ctrl dut (
`endif
    .SYS_clk      (clk),
    .SYS_reset    (rst_n),
    .LSU_start    (start),
    .LSU_write    (write),
    .LSU_size     (size),
    .LSU_unsigned (uns),
    .LSU_address  (address),
    .LSU_wdata    (wdata),
    .LSU_rdata    (rdata),
    .LSU_busy     (busy),
    .LSU_done     (done),
    .LSU_exception(exc),
    .LSU_exc_code (exc_code),
    .LSU_bad_addr (bad_addr),
    .dmem         (dmem.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; memory acks in the nreq-th cycle after start. Returns in the done cycle.
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int nreq, input logic [31:0] mem);
    next_cycle();
    write = w; size = sz; uns = u; address = a; wdata = wd; start = 1'b1;
    #1 o_busy0 = busy;
    next_cycle();
    start = 1'b0;
    o_req_cycles = 0;
    for (int i = 1; i <= nreq; i++) begin
      if (dmem.DMEM_req) o_req_cycles++;
      if (i == nreq) begin
        dmem.DMEM_ack = 1'b1;
        dmem.DMEM_data_out = mem;
        o_addr = dmem.DMEM_address;
        o_we   = dmem.DMEM_we;
        o_be   = dmem.DMEM_byte_en;
        o_din  = dmem.DMEM_data_in;
      end
      next_cycle();
      dmem.DMEM_ack = 1'b0;
    end
    #1;
    o_done = done; o_busy_done = busy; o_req_after = dmem.DMEM_req; o_exc = exc;
  endtask

  // Issue a faulting op and check the exception cycle plus the cycle after.
  task automatic fault(input string tag, input logic [1:0] sz, input logic [31:0] a,
                       input logic [1:0] exp_code);
    next_cycle();
    write = 1'b0; size = sz; uns = 1'b0; address = a; start = 1'b1;
    #1 chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    next_cycle();
    start = 1'b0;
    #1;
    chk({tag, "_exc"},  32'(exc), 32'd1);
    chk({tag, "_code"}, 32'(exc_code), 32'(exp_code));
    chk({tag, "_bad"},  bad_addr, a);
    chk({tag, "_noreq"}, 32'(dmem.DMEM_req), 32'd0);
    chk({tag, "_busy_err"}, 32'(busy), 32'd0);
    next_cycle();
    chk({tag, "_exc_pulse"}, 32'(exc), 32'd0);
    chk({tag, "_code_hold"}, 32'(exc_code), 32'(exp_code));
    chk({tag, "_noreq2"}, 32'(dmem.DMEM_req), 32'd0);
  endtask

  initial begin
    int cnt;
    logic seen_exc;
    dmem.DMEM_ack = 1'b0;
    dmem.DMEM_data_out = '0;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_exc", {30'd0, done, exc}, 32'd0);
    chk("rst_code", 32'(exc_code), 32'd0);
    chk("rst_bad", bad_addr, 32'h0);
    chk("rst_dmem", {27'd0, dmem.DMEM_req, dmem.DMEM_byte_en}, 32'd0);
    chk("rst_dmem_addr", dmem.DMEM_address, 32'h0);
    chk("rst_dmem_din", dmem.DMEM_data_in, 32'h0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // word store, ack in 2nd req cycle
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0);
    chk("sw_busy0", 32'(o_busy0), 32'd1);
    chk("sw_reqcyc", o_req_cycles, 2);
    chk("sw_addr", o_addr, 32'h10);
    chk("sw_we", 32'(o_we), 32'd1);
    chk("sw_be", 32'(o_be), 32'hF);
    chk("sw_din", o_din, 32'hDEADBEEF);
    chk("sw_done", 32'(o_done), 32'd1);
    chk("sw_busy_done", 32'(o_busy_done), 32'd0);
    chk("sw_req_after", 32'(o_req_after), 32'd0);
    next_cycle();
    chk("sw_done_pulse", 32'(done), 32'd0);

    // signed byte load at offset 3
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1, 32'h80AABBCC);
    chk("lb_be", 32'(o_be), 32'h8);
    chk("lb_we", 32'(o_we), 32'd0);
    chk("lb_addr", o_addr, 32'h10);
    chk("lb_done", 32'(o_done), 32'd1);
    chk("lb_rdata", rdata, 32'hFFFFFF80);

    access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1, 32'h80AABBCC);
    chk("lbu_rdata", rdata, 32'h00000080);

    access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1, 32'h80AABBCC);
    chk("lb1_be", 32'(o_be), 32'h2);
    chk("lb1_rdata", rdata, 32'hFFFFFFBB);

    // half store at offset 2; rdata must keep the previous load
    access(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 3, 32'hFFFFFFFF);
    chk("sh_reqcyc", o_req_cycles, 3);
    chk("sh_be", 32'(o_be), 32'hC);
    chk("sh_din", o_din, 32'h12341234);
    chk("sh_addr", o_addr, 32'h20);
    chk("sh_rdata_hold", rdata, 32'hFFFFFFBB);

    access(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1, 32'hBEEF0000);
    chk("lhu_rdata", rdata, 32'h0000BEEF);
    access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1, 32'hBEEF0000);
    chk("lh_rdata", rdata, 32'hFFFFBEEF);

    fault("mis_w", 2'b10, 32'h21, 2'b01);
    fault("mis_h", 2'b01, 32'h23, 2'b01);
    fault("ill_sz", 2'b11, 32'h40, 2'b11);

`ifdef LSU_TIMEOUT_EN
    next_cycle();
    write = 1'b0; size = 2'b10; uns = 1'b0; address = 32'h104; start = 1'b1;
    next_cycle();
    start = 1'b0;
    cnt = 0; seen_exc = 1'b0;
    for (int i = 0; i < 50 && !seen_exc; i++) begin
      if (exc) seen_exc = 1'b1;
      else begin
        if (dmem.DMEM_req) cnt++;
        next_cycle();
      end
    end
    chk("to_seen", 32'(seen_exc), 32'd1);
    chk("to_reqcyc", cnt, 4);
    chk("to_code", 32'(exc_code), 32'h2);
    chk("to_bad", bad_addr, 32'h104);
    chk("to_noreq", 32'(dmem.DMEM_req), 32'd0);

    access(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 4, 32'h5A5A1234);
    chk("to_ack_done", 32'(o_done), 32'd1);
    chk("to_ack_noexc", 32'(o_exc), 32'd0);
    chk("to_ack_rdata", rdata, 32'h5A5A1234);
`else
    next_cycle();
    write = 1'b0; size = 2'b10; uns = 1'b0; address = 32'h104; start = 1'b1;
    next_cycle();
    start = 1'b0;
    cnt = 0; seen_exc = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (dmem.DMEM_req) cnt++;
      if (exc) seen_exc = 1'b1;
      next_cycle();
    end
    chk("noto_reqcyc", cnt, 120);
    chk("noto_noexc", 32'(seen_exc), 32'd0);
    dmem.DMEM_ack = 1'b1;
    dmem.DMEM_data_out = 32'h5A5A1234;
    next_cycle();
    dmem.DMEM_ack = 1'b0;
    chk("noto_done", 32'(done), 32'd1);
    chk("noto_rdata", rdata, 32'h5A5A1234);
`endif

    // reset in the 2nd REQ cycle
    next_cycle();
    write = 1'b0; size = 2'b10; uns = 1'b0; address = 32'h8; start = 1'b1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    chk("mr_req_before", 32'(dmem.DMEM_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_req", 32'(dmem.DMEM_req), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_rdata", rdata, 32'h0);
    chk("mr_code_bad", {exc_code, bad_addr[29:0]}, 32'h0);
    chk("mr_be_addr", {dmem.DMEM_byte_en, dmem.DMEM_address[27:0]}, 32'h0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 2, 32'hCAFEF00D);
    chk("pr_addr", o_addr, 32'h8);
    chk("pr_be", 32'(o_be), 32'hF);
    chk("pr_done", 32'(o_done), 32'd1);
    chk("pr_rdata", rdata, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
